// File: rtl/flash_loader.sv
// flash_loader: copies LENGTH bytes from a serial-flash reader into memory
// at reset-time-fixed source/destination bases, one byte per request.
module flash_loader #(
  parameter logic [23:0] SRC_BASE = 24'h100000,
  parameter logic [15:0] DST_BASE = 16'h0000,
  parameter logic [16:0] LENGTH   = 17'd16384
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        start,
  input  logic        flash_ready,
  input  logic        flash_busy,
  input  logic [7:0]  flash_dout,
  output logic [23:0] flash_addr,
  output logic        flash_cs,
  output logic [15:0] mem_addr,
  output logic [7:0]  mem_data,
  output logic        mem_we,
  input  logic        mem_ack,
  output logic        active,
  output logic        done
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_RDY,
    S_REQ,
    S_WAIT_HI,
    S_WAIT_LO,
    S_WRITE,
    S_FIN
  } state_t;

  state_t      r_state;
  logic [16:0] r_offset;
  logic [23:0] r_faddr;
  logic        r_cs;
  logic [15:0] r_maddr;
  logic [7:0]  r_mdata;
  logic        r_we;
  logic        r_active;
  logic        r_done;

  logic [23:0] w_src;
  logic [15:0] w_dst;
  logic [16:0] w_next;
  logic        w_last;

  // 17-bit offset so that LENGTH=65536 still reaches its terminal count
  assign w_src  = SRC_BASE + {7'd0, r_offset};
  assign w_dst  = DST_BASE + r_offset[15:0];
  assign w_next = r_offset + 17'd1;
  assign w_last = (w_next == LENGTH);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state  <= S_IDLE;
      r_offset <= '0;
      r_faddr  <= '0;
      r_cs     <= 1'b0;
      r_maddr  <= '0;
      r_mdata  <= '0;
      r_we     <= 1'b0;
      r_active <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (start) begin
            r_offset <= '0;
            r_done   <= 1'b0;
            r_active <= 1'b1;
            r_state  <= (LENGTH == 17'd0) ? S_FIN : S_WAIT_RDY;
          end
        end
        S_WAIT_RDY: begin
          if (flash_ready && !flash_busy) r_state <= S_REQ;
        end
        S_REQ: begin
          r_faddr <= w_src;
          r_cs    <= 1'b1;
          r_state <= S_WAIT_HI;
        end
        S_WAIT_HI: begin
          if (flash_busy) begin
            r_cs    <= 1'b0;
            r_state <= S_WAIT_LO;
          end
        end
        S_WAIT_LO: begin
          if (!flash_busy) begin
            r_mdata <= flash_dout;
            r_maddr <= w_dst;
            r_we    <= 1'b1;
            r_state <= S_WRITE;
          end
        end
        S_WRITE: begin
          if (mem_ack) begin
            r_we     <= 1'b0;
            r_offset <= w_next;
            r_state  <= w_last ? S_FIN : S_REQ;
          end
        end
        S_FIN: begin
          r_active <= 1'b0;
          r_done   <= 1'b1;
          r_state  <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign flash_addr = r_faddr;
  assign flash_cs   = r_cs;
  assign mem_addr   = r_maddr;
  assign mem_data   = r_mdata;
  assign mem_we     = r_we;
  assign active     = r_active;
  assign done       = r_done;

endmodule

// File: tb/tb_flash_loader.sv
// tb_flash_loader: randomized flash/memory models with a queue scoreboard
// for flash_loader (wrapping 4-byte copy and a zero-length instance).
module tb_flash_loader;

  localparam logic [23:0] SRC0 = 24'hFFFFFE;
  localparam logic [15:0] DST0 = 16'hFFFE;
  localparam int          LEN0 = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        resetn;
  logic        st0, rdy0, busy0, ack0;
  logic [7:0]  dout0;
  logic [23:0] fa0;
  logic        cs0, we0, act0, dn0;
  logic [15:0] ma0;
  logic [7:0]  md0;

  logic        st1, rdy1, busy1, ack1;
  logic [7:0]  dout1;
  logic [23:0] fa1;
  logic        cs1, we1, act1, dn1;
  logic [15:0] ma1;
  logic [7:0]  md1;

  flash_loader #(
    .SRC_BASE(SRC0),
    .DST_BASE(DST0),
    .LENGTH  (17'd4)
  ) u_dut0 (
    .clk        (clk),
    .resetn     (resetn),
    .start      (st0),
    .flash_ready(rdy0),
    .flash_busy (busy0),
    .flash_dout (dout0),
    .flash_addr (fa0),
    .flash_cs   (cs0),
    .mem_addr   (ma0),
    .mem_data   (md0),
    .mem_we     (we0),
    .mem_ack    (ack0),
    .active     (act0),
    .done       (dn0)
  );

  flash_loader #(
    .LENGTH(17'd0)
  ) u_dut1 (
    .clk        (clk),
    .resetn     (resetn),
    .start      (st1),
    .flash_ready(rdy1),
    .flash_busy (busy1),
    .flash_dout (dout1),
    .flash_addr (fa1),
    .flash_cs   (cs1),
    .mem_addr   (ma1),
    .mem_data   (md1),
    .mem_we     (we1),
    .mem_ack    (ack1),
    .active     (act1),
    .done       (dn1)
  );

  int checks   = 0;
  int failures = 0;

  logic [23:0] exp_fa[$];
  logic [23:0] exp_wr[$];

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Reference: byte i is read from SRC+i and written to DST+i as addr^A5
  task automatic push_copy();
    logic [23:0] a;
    logic [15:0] d;
    for (int i = 0; i < LEN0; i++) begin
      a = SRC0 + 24'(i);
      d = DST0 + 16'(i);
      exp_fa.push_back(a);
      exp_wr.push_back({d, a[7:0] ^ 8'hA5});
    end
  endtask

  // Flash reader model
  int          fl_phase = 0;
  int          fl_cnt   = 0;
  logic        fl_pcs   = 1'b0;
  logic [23:0] fl_addr  = '0;
  initial begin
    busy0 = 1'b0;
    dout0 = 8'h00;
    forever begin
      @(negedge clk);
      if (!resetn) begin
        fl_phase = 0;
        busy0    = 1'b0;
        fl_pcs   = 1'b0;
      end else begin
        case (fl_phase)
          0: if (cs0 && !fl_pcs) begin
            fl_addr  = fa0;
            fl_cnt   = int'($urandom_range(3, 30));
            fl_phase = 1;
            dout0    = 8'($urandom);
          end
          1: begin
            fl_cnt--;
            if (fl_cnt == 0) begin
              busy0    = 1'b1;
              fl_cnt   = int'($urandom_range(1, 5));
              fl_phase = 2;
            end
          end
          default: begin
            fl_cnt--;
            if (fl_cnt == 0) begin
              busy0    = 1'b0;
              dout0    = fl_addr[7:0] ^ 8'hA5;
              fl_phase = 0;
            end
          end
        endcase
        fl_pcs = cs0;
      end
    end
  end

  // Memory acknowledge model, with occasional stray acks outside a write
  int ack_dly = -1;
  initial begin
    ack0 = 1'b0;
    forever begin
      @(negedge clk);
      ack0 = 1'b0;
      if (!resetn) begin
        ack_dly = -1;
      end else if (we0) begin
        if (ack_dly < 0) ack_dly = int'($urandom_range(0, 7));
        if (ack_dly == 0) begin
          ack0    = 1'b1;
          ack_dly = -1;
        end else begin
          ack_dly--;
        end
      end else begin
        ack_dly = -1;
        if ($urandom_range(0, 7) == 0) ack0 = 1'b1;
      end
    end
  end

  // Monitor / scoreboard
  logic        m_pwe  = 1'b0;
  logic        m_pcs  = 1'b0;
  logic        m_hfa  = 1'b0;
  logic [15:0] h_ma   = '0;
  logic [7:0]  h_md   = '0;
  logic [23:0] h_fa   = '0;
  int          lo_gap = 2;
  initial begin
    logic [23:0] e;
    forever begin
      @(negedge clk);
      if (!resetn) begin
        m_pwe  = 1'b0;
        m_pcs  = 1'b0;
        m_hfa  = 1'b0;
        lo_gap = 2;
      end else begin
        if (we0 && !m_pwe) begin
          if (exp_wr.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_write actual=%0h required=none",
                     {ma0, md0});
          end else begin
            e = exp_wr.pop_front();
            chk("wr_addr", 64'(ma0), 64'(e[23:8]));
            chk("wr_data", 64'(md0), 64'(e[7:0]));
          end
          h_ma = ma0;
          h_md = md0;
        end else if (we0) begin
          chk("wr_hold_addr", 64'(ma0), 64'(h_ma));
          chk("wr_hold_data", 64'(md0), 64'(h_md));
        end
        if (cs0 && !m_pcs) begin
          chk("cs_low_gap", 64'(lo_gap >= 2), 64'd1);
          if (exp_fa.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_read actual=%0h required=none", fa0);
          end else begin
            e = exp_fa.pop_front();
            chk("flash_addr", 64'(fa0), 64'(e));
          end
          h_fa  = fa0;
          m_hfa = 1'b1;
        end else if (m_hfa) begin
          chk("flash_addr_hold", 64'(fa0), 64'(h_fa));
        end
        if (we0) m_hfa = 1'b0;
        lo_gap = cs0 ? 0 : lo_gap + 1;
        m_pwe  = we0;
        m_pcs  = cs0;
      end
    end
  end

  logic bad1 = 1'b0;
  always @(negedge clk) if (cs1 || we1) bad1 = 1'b1;

  task automatic pulse0(input bit check);
    @(negedge clk);
    st0 = 1'b1;
    @(negedge clk);
    st0 = 1'b0;
    if (check) begin
      chk("start_active", 64'(act0), 64'd1);
      chk("start_done_clr", 64'(dn0), 64'd0);
    end
  endtask

  task automatic wait_done0();
    int n = 0;
    while (!dn0 && n < 5000) begin
      @(negedge clk);
      n++;
    end
    chk("done_set", 64'(dn0), 64'd1);
    chk("active_clr", 64'(act0), 64'd0);
    chk("writes_left", 64'(exp_wr.size()), 64'd0);
    chk("reads_left", 64'(exp_fa.size()), 64'd0);
    repeat (3) @(negedge clk);
    chk("done_sticky", 64'(dn0), 64'd1);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int  n;
    bit  bad;
    resetn = 1'b0;
    st0 = 1'b0; rdy0 = 1'b1;
    st1 = 1'b0; rdy1 = 1'b1; busy1 = 1'b0; dout1 = 8'h00; ack1 = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_outs0", 64'({fa0, cs0, ma0, md0, we0, act0, dn0}), 64'd0);
    chk("reset_outs1", 64'({fa1, cs1, ma1, md1, we1, act1, dn1}), 64'd0);
    resetn = 1'b1;
    repeat (2) @(negedge clk);

    // plain copy
    push_copy();
    pulse0(1'b1);
    wait_done0();

    // flash not ready for 100 cycles
    rdy0 = 1'b0;
    push_copy();
    pulse0(1'b1);
    bad = 1'b0;
    repeat (100) begin
      @(negedge clk);
      if (cs0) bad = 1'b1;
    end
    chk("cs_while_not_ready", 64'(bad), 64'd0);
    rdy0 = 1'b1;
    wait_done0();

    // start while busy is ignored
    push_copy();
    pulse0(1'b1);
    repeat (15) @(negedge clk);
    pulse0(1'b0);
    wait_done0();

    // reset during the write of byte 2
    push_copy();
    pulse0(1'b1);
    n = 0;
    while (!(we0 && ma0 == 16'(DST0 + 16'd2)) && n < 5000) begin
      @(negedge clk);
      n++;
    end
    chk("reach_byte2", 64'(we0 && ma0 == 16'(DST0 + 16'd2)), 64'd1);
    #2 resetn = 1'b0;
    #1 chk("async_reset_outs",
           64'({fa0, cs0, ma0, md0, we0, act0, dn0}), 64'd0);
    exp_wr.delete();
    exp_fa.delete();
    repeat (3) @(negedge clk);
    resetn = 1'b1;
    repeat (60) @(negedge clk);
    chk("idle_after_abort", 64'({act0, dn0}), 64'd0);
    push_copy();
    pulse0(1'b1);
    wait_done0();

    // extra randomized copies
    repeat (2) begin
      push_copy();
      pulse0(1'b1);
      wait_done0();
    end

    // zero-length instance
    @(negedge clk);
    st1 = 1'b1;
    @(negedge clk);
    st1 = 1'b0;
    n = 0;
    while (!dn1 && n < 2) begin
      @(negedge clk);
      n++;
    end
    chk("len0_done", 64'(dn1), 64'd1);
    chk("len0_active", 64'(act1), 64'd0);
    repeat (5) @(negedge clk);
    chk("len0_no_activity", 64'(bad1), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
